// File: rtl/mips_pkg.sv
// Shared MIPS EX-stage definitions: ALUCtrl codes (shared with the ALU controller),
// datapath width and the multiply/divide FSM state encoding.
package mips_pkg;

  localparam int unsigned XLEN  = 32;
  // Iteration counter width; must be able to hold XLEN.
  localparam int unsigned CNT_W = 6;

  localparam logic [4:0] AluCtrlMult = 5'b00010;
  localparam logic [4:0] AluCtrlMfhi = 5'b01001;
  localparam logic [4:0] AluCtrlMflo = 5'b01010;
  localparam logic [4:0] AluCtrlMthi = 5'b01011;
  localparam logic [4:0] AluCtrlMtlo = 5'b01100;
  localparam logic [4:0] AluCtrlDiv  = 5'b10011;

  typedef enum logic [1:0] {
    StIdle,
    StMul,
    StDiv,
    StFix
  } md_state_e;

  // True for every code that touches the HI/LO unit and therefore must wait while it is busy.
  function automatic logic is_md_code(logic [4:0] code);
    return (code == AluCtrlMult) || (code == AluCtrlMfhi) || (code == AluCtrlMflo) ||
           (code == AluCtrlMthi) || (code == AluCtrlMtlo) || (code == AluCtrlDiv);
  endfunction

endpackage

// File: rtl/hilo_muldiv_unit_if.sv
// EX-stage <-> multiply/divide unit bundle.
//   master: EX stage (drives instruction/operands, reads HI/LO and stall)
//   slave : hilo_muldiv_unit
// Signals: valid_in, flush, alu_ctrl[4:0], unsgn, rs_val, rt_val (to unit);
//          hi_out, lo_out, busy, md_stall (from unit).
interface hilo_muldiv_unit_if;
  import mips_pkg::*;

  logic            valid_in;
  logic            flush;
  logic [4:0]      alu_ctrl;
  logic            unsgn;
  logic [XLEN-1:0] rs_val;
  logic [XLEN-1:0] rt_val;
  logic [XLEN-1:0] hi_out;
  logic [XLEN-1:0] lo_out;
  logic            busy;
  logic            md_stall;

  modport master (
    output valid_in, flush, alu_ctrl, unsgn, rs_val, rt_val,
    input  hi_out, lo_out, busy, md_stall
  );

  modport slave (
    input  valid_in, flush, alu_ctrl, unsgn, rs_val, rt_val,
    output hi_out, lo_out, busy, md_stall
  );

endinterface

// File: rtl/muldiv_iter_core.sv
// Iterative radix-2 multiply/divide datapath operating on unsigned magnitudes.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   load          latch a_mag/b_mag, clear accumulator and counter
//   op_div        operation selected at load (1 = restoring divide, 0 = shift-add multiply)
//   a_mag, b_mag  multiplicand/dividend and multiplier/divisor magnitudes
//   step          perform one iteration this cycle
//   acc_hi        product high half / remainder
//   acc_lo        product low half / quotient
//   last          the current step is the final (XLEN-th) one
module muldiv_iter_core
  import mips_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            op_div,
  input  logic [XLEN-1:0] a_mag,
  input  logic [XLEN-1:0] b_mag,
  input  logic            step,
  output logic [XLEN-1:0] acc_hi,
  output logic [XLEN-1:0] acc_lo,
  output logic            last
);

  logic [XLEN-1:0]  hi_q, lo_q, b_q;
  logic             op_div_q;
  logic [CNT_W-1:0] cnt_q;

  logic [XLEN:0]    mul_sum;
  logic [XLEN:0]    rem_sh;
  logic [XLEN:0]    rem_diff;
  logic             rem_ge;
  logic [XLEN-1:0]  nxt_hi, nxt_lo;

  // Multiply: {hi,lo} holds partial product above the remaining multiplier bits.
  // Divide:   hi is the partial remainder, lo shifts dividend bits out and quotient bits in.
  always_comb begin
    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    rem_sh   = {hi_q, lo_q[XLEN-1]};
    rem_diff = rem_sh - {1'b0, b_q};
    rem_ge   = rem_sh >= {1'b0, b_q};
    if (op_div_q) begin
      nxt_hi = rem_ge ? rem_diff[XLEN-1:0] : rem_sh[XLEN-1:0];
      nxt_lo = {lo_q[XLEN-2:0], rem_ge};
    end else begin
      nxt_hi = mul_sum[XLEN:1];
      nxt_lo = {mul_sum[0], lo_q[XLEN-1:1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q     <= '0;
      lo_q     <= '0;
      b_q      <= '0;
      op_div_q <= 1'b0;
      cnt_q    <= '0;
    end else if (load) begin
      hi_q     <= '0;
      lo_q     <= a_mag;
      b_q      <= b_mag;
      op_div_q <= op_div;
      cnt_q    <= '0;
    end else if (step) begin
      hi_q  <= nxt_hi;
      lo_q  <= nxt_lo;
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign acc_hi = hi_q;
  assign acc_lo = lo_q;
  assign last   = cnt_q == CNT_W'(XLEN - 1);

endmodule

// File: rtl/hilo_muldiv_unit.sv
// EX-stage multiply/divide unit with architectural HI/LO registers.
// Runs mult/multu/div/divu iteratively (XLEN steps plus one sign-fix cycle), services
// mfhi/mflo/mthi/mtlo and stalls MD instructions while a result is pending.
// Ports:
//   clk, rst  clock, asynchronous active-high reset
//   bus       hilo_muldiv_unit_if.slave: valid_in, flush, alu_ctrl, unsgn, rs_val, rt_val in;
//             hi_out, lo_out, busy, md_stall out
// Configuration: define MIPS_FAST_MULT_EN for a single-cycle multiplier (HI/LO written on the
// accept edge, busy never raised for mult). Divide is iterative in both builds.
module hilo_muldiv_unit
  import mips_pkg::*;
(
  input logic               clk,
  input logic               rst,
  hilo_muldiv_unit_if.slave bus
);

  md_state_e       state_q;
  logic [XLEN-1:0] hi_q, lo_q;
  logic            neg_lo_q, neg_hi_q, div_zero_q, op_div_q;

  logic            is_mult, is_div, busy, accept;
  logic            rs_neg, rt_neg;
  logic [XLEN-1:0] rs_mag, rt_mag;

  logic            core_load, core_step, core_last;
  logic [XLEN-1:0] core_hi, core_lo;

  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, fix_hi, fix_lo;

  assign is_mult = bus.alu_ctrl == AluCtrlMult;
  assign is_div  = bus.alu_ctrl == AluCtrlDiv;
  assign busy    = state_q != StIdle;
  assign accept  = bus.valid_in & ~busy & ~bus.flush;

  assign rs_neg = ~bus.unsgn & bus.rs_val[XLEN-1];
  assign rt_neg = ~bus.unsgn & bus.rt_val[XLEN-1];
  assign rs_mag = rs_neg ? -bus.rs_val : bus.rs_val;
  assign rt_mag = rt_neg ? -bus.rt_val : bus.rt_val;

`ifdef MIPS_FAST_MULT_EN
  logic signed [XLEN:0]     fast_a, fast_b;
  logic signed [2*XLEN-1:0] fast_prod;

  assign fast_a    = $signed({rs_neg, bus.rs_val});
  assign fast_b    = $signed({rt_neg, bus.rt_val});
  assign fast_prod = fast_a * fast_b;
  assign core_load = accept & is_div;
`else
  assign core_load = accept & (is_mult | is_div);
`endif

  assign core_step = (state_q == StMul) | (state_q == StDiv);

  muldiv_iter_core u_core (
    .clk    (clk),
    .rst    (rst),
    .load   (core_load),
    .op_div (is_div),
    .a_mag  (rs_mag),
    .b_mag  (rt_mag),
    .step   (core_step),
    .acc_hi (core_hi),
    .acc_lo (core_lo),
    .last   (core_last)
  );

  // Sign correction of the magnitude results. -2^31 / -1 needs no special case: the magnitude
  // quotient is already 32'h8000_0000 and both signs cancel. Divide by zero leaves the dividend
  // magnitude as remainder, which the dividend sign turns back into rs_val.
  always_comb begin
    prod_fix = {core_hi, core_lo};
    if (neg_lo_q) prod_fix = -prod_fix;
    quo_fix = neg_lo_q ? -core_lo : core_lo;
    if (div_zero_q) quo_fix = '1;
    rem_fix = neg_hi_q ? -core_hi : core_hi;
    if (op_div_q) begin
      fix_hi = rem_fix;
      fix_lo = quo_fix;
    end else begin
      fix_hi = prod_fix[2*XLEN-1:XLEN];
      fix_lo = prod_fix[XLEN-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      hi_q       <= '0;
      lo_q       <= '0;
      neg_lo_q   <= 1'b0;
      neg_hi_q   <= 1'b0;
      div_zero_q <= 1'b0;
      op_div_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept && is_div) begin
            state_q    <= StDiv;
            op_div_q   <= 1'b1;
            neg_lo_q   <= rs_neg ^ rt_neg;
            neg_hi_q   <= rs_neg;
            div_zero_q <= bus.rt_val == '0;
          end else if (accept && is_mult) begin
`ifdef MIPS_FAST_MULT_EN
            hi_q <= fast_prod[2*XLEN-1:XLEN];
            lo_q <= fast_prod[XLEN-1:0];
`else
            state_q    <= StMul;
            op_div_q   <= 1'b0;
            neg_lo_q   <= rs_neg ^ rt_neg;
            neg_hi_q   <= 1'b0;
            div_zero_q <= 1'b0;
`endif
          end else if (bus.valid_in && bus.alu_ctrl == AluCtrlMthi) begin
            hi_q <= bus.rs_val;
          end else if (bus.valid_in && bus.alu_ctrl == AluCtrlMtlo) begin
            lo_q <= bus.rs_val;
          end
        end
        StMul, StDiv: begin
          if (bus.flush) state_q <= StIdle;
          else if (core_last) state_q <= StFix;
        end
        StFix: begin
          state_q <= StIdle;
          if (!bus.flush) begin
            hi_q <= fix_hi;
            lo_q <= fix_lo;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.hi_out   = hi_q;
  assign bus.lo_out   = lo_q;
  assign bus.busy     = busy;
  // mthi/mtlo while idle are never stalled, so they cannot collide with a FIX write.
  assign bus.md_stall = bus.valid_in & busy & is_md_code(bus.alu_ctrl);

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
module tb_hilo_muldiv_unit;
  import mips_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hilo_muldiv_unit_if bus ();

  hilo_muldiv_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

`ifdef MIPS_FAST_MULT_EN
  localparam int MulLat = 0;
`else
  localparam int MulLat = 33;
`endif
  localparam int DivLat = 33;

  typedef struct {
    string       name;
    logic [4:0]  code;
    logic        uns;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Architectural reference: plain 64-bit arithmetic on the interpreted operands.
  function automatic void model(input logic is_div, input logic uns, input logic [31:0] a,
                                input logic [31:0] b, output logic [31:0] h,
                                output logic [31:0] l);
    longint sa, sb, p, q, r;
    sa = uns ? longint'({32'b0, a}) : longint'($signed(a));
    sb = uns ? longint'({32'b0, b}) : longint'($signed(b));
    if (!is_div) begin
      p = sa * sb;
      h = p[63:32];
      l = p[31:0];
    end else if (b == 32'd0) begin
      l = 32'hFFFF_FFFF;
      h = a;
    end else begin
      q = sa / sb;
      r = sa % sb;
      l = q[31:0];
      h = r[31:0];
    end
  endfunction

  // Issue one op (called at posedge+1, unit idle); returns number of busy cycles seen.
  task automatic run_op(input logic [4:0] c, input logic u, input logic [31:0] a,
                        input logic [31:0] b, output int lat);
    bus.valid_in = 1'b1;
    bus.alu_ctrl = c;
    bus.unsgn    = u;
    bus.rs_val   = a;
    bus.rt_val   = b;
    @(posedge clk); #1;
    bus.valid_in = 1'b0;
    bus.alu_ctrl = 5'b00000;
    lat = 0;
    while (bus.busy && lat < 100) begin
      lat++;
      @(posedge clk); #1;
    end
  endtask

  task automatic check_op(input string nm, input logic [4:0] c, input logic u,
                          input logic [31:0] a, input logic [31:0] b);
    int lat;
    logic [31:0] eh, el;
    model(c == AluCtrlDiv, u, a, b, eh, el);
    run_op(c, u, a, b, lat);
    chk({nm, ".lat"}, 64'(lat), 64'((c == AluCtrlDiv) ? DivLat : MulLat));
    chk({nm, ".hi"}, {32'b0, bus.hi_out}, {32'b0, eh});
    chk({nm, ".lo"}, {32'b0, bus.lo_out}, {32'b0, el});
  endtask

  task automatic move_to(input logic [4:0] c, input logic [31:0] v);
    bus.valid_in = 1'b1;
    bus.alu_ctrl = c;
    bus.rs_val   = v;
    @(posedge clk); #1;
    bus.valid_in = 1'b0;
    bus.alu_ctrl = 5'b00000;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (bus.busy && n < 100) begin
      n++;
      @(posedge clk); #1;
    end
    if (bus.busy) chk({nm, ".idle_timeout"}, 64'(bus.busy), 64'd0);
  endtask

  initial begin
    int cnt;
    logic [31:0] a, b;

    vecs[0] = '{"mult_m3x7",   AluCtrlMult, 1'b0, 32'hFFFF_FFFD, 32'd7,
                32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[1] = '{"multu_m3x7",  AluCtrlMult, 1'b1, 32'hFFFF_FFFD, 32'd7,
                32'h0000_0006, 32'hFFFF_FFEB};
    vecs[2] = '{"mult_minsq",  AluCtrlMult, 1'b0, 32'h8000_0000, 32'h8000_0000,
                32'h4000_0000, 32'h0000_0000};
    vecs[3] = '{"div_m7_2",    AluCtrlDiv,  1'b0, 32'hFFFF_FFF9, 32'd2,
                32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[4] = '{"div_7_m2",    AluCtrlDiv,  1'b0, 32'd7, 32'hFFFF_FFFE,
                32'd1, 32'hFFFF_FFFD};
    vecs[5] = '{"divu_7_0",    AluCtrlDiv,  1'b1, 32'd7, 32'd0,
                32'd7, 32'hFFFF_FFFF};
    vecs[6] = '{"div_ovf",     AluCtrlDiv,  1'b0, 32'h8000_0000, 32'hFFFF_FFFF,
                32'd0, 32'h8000_0000};
    vecs[7] = '{"divu_100_7",  AluCtrlDiv,  1'b1, 32'd100, 32'd7,
                32'd2, 32'd14};

    bus.valid_in = 1'b0;
    bus.flush    = 1'b0;
    bus.alu_ctrl = 5'b00000;
    bus.unsgn    = 1'b0;
    bus.rs_val   = '0;
    bus.rt_val   = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    chk("reset.busy", 64'(bus.busy), 64'd0);
    chk("reset.stall", 64'(bus.md_stall), 64'd0);
    chk("reset.hi", {32'b0, bus.hi_out}, 64'd0);
    chk("reset.lo", {32'b0, bus.lo_out}, 64'd0);

    // Directed vectors.
    for (int i = 0; i < 8; i++) begin
      int lat;
      run_op(vecs[i].code, vecs[i].uns, vecs[i].rs, vecs[i].rt, lat);
      chk({vecs[i].name, ".lat"}, 64'(lat),
          64'((vecs[i].code == AluCtrlDiv) ? DivLat : MulLat));
      chk({vecs[i].name, ".hi"}, {32'b0, bus.hi_out}, {32'b0, vecs[i].hi});
      chk({vecs[i].name, ".lo"}, {32'b0, bus.lo_out}, {32'b0, vecs[i].lo});
    end

    // mthi / mtlo.
    move_to(AluCtrlMthi, 32'hDEAD_BEEF);
    chk("mthi.hi", {32'b0, bus.hi_out}, 64'hDEAD_BEEF);
    move_to(AluCtrlMtlo, 32'h1234_5678);
    chk("mtlo.lo", {32'b0, bus.lo_out}, 64'h1234_5678);
    chk("mtlo.hi_kept", {32'b0, bus.hi_out}, 64'hDEAD_BEEF);

    // flush at iteration 10 of a div: HI/LO keep prior values.
    bus.valid_in = 1'b1; bus.alu_ctrl = AluCtrlDiv; bus.unsgn = 1'b0;
    bus.rs_val = 32'd1000; bus.rt_val = 32'd3;
    @(posedge clk); #1;
    bus.valid_in = 1'b0; bus.alu_ctrl = 5'b00000;
    repeat (9) begin @(posedge clk); #1; end
    chk("flush10.busy_before", 64'(bus.busy), 64'd1);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    chk("flush10.busy_after1", 64'(bus.busy), 64'd0);
    @(posedge clk); #1;
    chk("flush10.busy_after2", 64'(bus.busy), 64'd0);
    chk("flush10.hi", {32'b0, bus.hi_out}, 64'hDEAD_BEEF);
    chk("flush10.lo", {32'b0, bus.lo_out}, 64'h1234_5678);
    check_op("mult_5x6", AluCtrlMult, 1'b0, 32'd5, 32'd6);

    // flush during the fix cycle suppresses the write.
    bus.valid_in = 1'b1; bus.alu_ctrl = AluCtrlDiv; bus.unsgn = 1'b1;
    bus.rs_val = 32'd100; bus.rt_val = 32'd7;
    @(posedge clk); #1;
    bus.valid_in = 1'b0; bus.alu_ctrl = 5'b00000;
    repeat (32) begin @(posedge clk); #1; end
    chk("flushfix.busy_in_fix", 64'(bus.busy), 64'd1);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    chk("flushfix.busy", 64'(bus.busy), 64'd0);
    chk("flushfix.hi", {32'b0, bus.hi_out}, 64'd0);
    chk("flushfix.lo", {32'b0, bus.lo_out}, 64'd30);

    // flush beats a simultaneous accept.
    bus.valid_in = 1'b1; bus.alu_ctrl = AluCtrlMult; bus.flush = 1'b1;
    bus.rs_val = 32'd2; bus.rt_val = 32'd3;
    @(posedge clk); #1;
    bus.valid_in = 1'b0; bus.alu_ctrl = 5'b00000; bus.flush = 1'b0;
    chk("flushacc.busy", 64'(bus.busy), 64'd0);
    chk("flushacc.lo", {32'b0, bus.lo_out}, 64'd30);

    // mflo right behind a mult stalls until the product is written.
    bus.valid_in = 1'b1; bus.alu_ctrl = AluCtrlMult; bus.unsgn = 1'b0;
    bus.rs_val = 32'hFFFF_FFFD; bus.rt_val = 32'd7;
    @(posedge clk); #1;
    bus.alu_ctrl = AluCtrlMflo;
    #1;
    cnt = 0;
    while (bus.md_stall && cnt < 100) begin
      cnt++;
      @(posedge clk); #2;
    end
    bus.valid_in = 1'b0; bus.alu_ctrl = 5'b00000;
    chk("mflo.stall_cycles", 64'(cnt), 64'(MulLat));
    chk("mflo.hi", {32'b0, bus.hi_out}, 64'hFFFF_FFFF);
    chk("mflo.lo", {32'b0, bus.lo_out}, 64'hFFFF_FFEB);

    // A non-MD instruction behind a busy unit is not stalled.
    @(posedge clk); #1;
    bus.valid_in = 1'b1; bus.alu_ctrl = AluCtrlDiv; bus.unsgn = 1'b0;
    bus.rs_val = 32'd9; bus.rt_val = 32'd2;
    @(posedge clk); #1;
    bus.alu_ctrl = 5'b00000;
    #1;
    chk("add.busy", 64'(bus.busy), 64'd1);
    chk("add.stall", 64'(bus.md_stall), 64'd0);
    bus.alu_ctrl = AluCtrlMfhi;
    #1;
    chk("mfhi_busy.stall", 64'(bus.md_stall), 64'd1);
    bus.valid_in = 1'b0; bus.alu_ctrl = 5'b00000;
    wait_idle("add");
    chk("div_9_2.hi", {32'b0, bus.hi_out}, 64'd1);
    chk("div_9_2.lo", {32'b0, bus.lo_out}, 64'd4);

    // Reset mid-divide.
    bus.valid_in = 1'b1; bus.alu_ctrl = AluCtrlDiv;
    bus.rs_val = 32'd77; bus.rt_val = 32'd5;
    @(posedge clk); #1;
    bus.valid_in = 1'b0; bus.alu_ctrl = 5'b00000;
    repeat (5) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    chk("rstmid.busy", 64'(bus.busy), 64'd0);
    chk("rstmid.hi", {32'b0, bus.hi_out}, 64'd0);
    chk("rstmid.lo", {32'b0, bus.lo_out}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rstmid.busy_after", 64'(bus.busy), 64'd0);

    // Randomised ops against the reference model.
    for (int i = 0; i < 40; i++) begin
      logic [4:0] c;
      logic u;
      c = ($urandom % 2) ? AluCtrlMult : AluCtrlDiv;
      u = 1'($urandom % 2);
      a = $urandom;
      b = ($urandom % 8 == 0) ? 32'd0 : (($urandom % 3 == 0) ? $urandom % 16 : $urandom);
      if ($urandom % 4 == 0) a = $urandom % 64;
      check_op($sformatf("rand%0d", i), c, u, a, b);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
